// File: rtl/elm_class_select_ctrl.sv
// Output-stage sequencer for the ELM classifier: collects one frame of signed
// class scores, finds the argmax (lowest index wins ties) and strobes the digit decoder.
module elm_class_select_ctrl #(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_data,
  output logic                      score_ready,
  output logic [IDX_W-1:0]          count_data,
  output logic                      en_digit,
  output logic                      rst_digit,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  logic [2:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      first_q, first_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          count_data_q, count_data_d;
  logic signed [SCORE_W-1:0] max_score_q, max_score_d;
  logic                      en_digit_q, en_digit_d;
  logic                      rst_digit_q, rst_digit_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      score_ready_q, score_ready_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    first_d      = first_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    count_data_d = count_data_q;
    max_score_d  = max_score_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        idx_d   = '0;
        first_d = 1'b1;
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // abort wins over a score arriving in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (score_valid) begin
          if (first_q || (score_data > best_q)) begin
            best_d     = score_data;
            best_idx_d = idx_q;
          end
          first_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_RESOLVE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_RESOLVE: begin
        count_data_d = best_idx_q;
        max_score_d  = best_q;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered copies of the state being entered
    rst_digit_d   = (state_d == S_CLEAR);
    score_ready_d = (state_d == S_COLLECT);
    en_digit_d    = (state_d == S_ISSUE);
    done_d        = (state_d == S_ISSUE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      first_q       <= 1'b0;
      best_q        <= '0;
      best_idx_q    <= '0;
      count_data_q  <= '0;
      max_score_q   <= '0;
      en_digit_q    <= 1'b0;
      rst_digit_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      score_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      first_q       <= first_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      count_data_q  <= count_data_d;
      max_score_q   <= max_score_d;
      en_digit_q    <= en_digit_d;
      rst_digit_q   <= rst_digit_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      score_ready_q <= score_ready_d;
    end
  end

  assign score_ready = score_ready_q;
  assign count_data  = count_data_q;
  assign en_digit    = en_digit_q;
  assign rst_digit   = rst_digit_q;
  assign max_score   = max_score_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
